// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests,
// and the producer side of the IF/ID register (instr/pc/pc+4/code).
module fetch_unit #(
    parameter int XLEN = 2,
    localparam int W = 1 << (XLEN + 4),
    parameter logic [W-1:0] RESET_VECTOR = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_stall_f,
    input  logic         i_redirect,
    input  logic [W-1:0] i_redirect_pc,
    input  logic         i_trap_redirect,
    input  logic [W-1:0] i_trap_pc,
    output logic         o_imem_req,
    output logic [W-1:0] o_imem_addr,
    input  logic         i_imem_ready,
    input  logic         i_imem_rvalid,
    input  logic [31:0]  i_imem_rdata,
    input  logic         i_imem_err,
    output logic [W-1:0] o_instr_f,
    output logic [W-1:0] o_pc_f,
    output logic [W-1:0] o_pc_p4_f,
    output logic [3:0]   o_exception_code_f,
    output logic         o_fetch_busy
);

    localparam logic [3:0]  NO_E                 = 4'hF;
    localparam logic [3:0]  E_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  E_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [31:0] NOP                  = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_FAULT
    } state_t;

    state_t      state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_err_q, buf_err_d;

    logic        req;
    logic        pres;
    logic [31:0] p_instr;
    logic [W-1:0] p_pc;
    logic [3:0]  p_code;
    logic        outstanding;

    // Next-state, PC advance, buffer capture and the presented entry.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_err_d   = buf_err_q;
        req         = 1'b0;
        pres        = 1'b0;
        p_instr     = NOP;
        p_pc        = '0;
        p_code      = NO_E;
        outstanding = 1'b0;

        unique case (state_q)
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    pres    = 1'b1;
                    p_instr = '0;
                    p_pc    = pc_q;
                    p_code  = E_INSTR_MISALIGNED;
                    if (!i_stall_f) state_d = S_FAULT;
                end else begin
                    req = 1'b1;
                    if (i_imem_ready) begin
                        state_d     = S_WAIT;
                        outstanding = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    pres    = 1'b1;
                    p_pc    = pc_q;
                    p_instr = i_imem_err ? 32'h0 : i_imem_rdata;
                    p_code  = i_imem_err ? E_INSTR_ACCESS_FAULT : NO_E;
                    if (i_stall_f) begin
                        buf_instr_d = p_instr;
                        buf_err_d   = i_imem_err;
                        state_d     = S_HOLD;
                    end else if (i_imem_err) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = pc_q + W'(4);
                        state_d = S_REQ;
                    end
                end else begin
                    outstanding = 1'b1;
                end
            end
            S_HOLD: begin
                pres    = 1'b1;
                p_pc    = pc_q;
                p_instr = buf_instr_q;
                p_code  = buf_err_q ? E_INSTR_ACCESS_FAULT : NO_E;
                if (!i_stall_f) begin
                    if (buf_err_q) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = pc_q + W'(4);
                        state_d = S_REQ;
                    end
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) state_d = S_REQ;
                else outstanding = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (i_trap_redirect || i_redirect) begin
            pc_d        = i_trap_redirect ? i_trap_pc : i_redirect_pc;
            buf_instr_d = '0;
            buf_err_d   = 1'b0;
            state_d     = outstanding ? S_DROP : S_REQ;
        end
    end

    // State, PC and hold buffer; reset wins over the clock enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_VECTOR;
            buf_instr_q <= '0;
            buf_err_q   <= 1'b0;
        end else if (i_clk_en) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_err_q   <= buf_err_d;
        end
    end

    // Drive the IF/ID outputs; anything not presented is a bubble.
    always_comb begin
        o_imem_req  = req & ~i_rst;
        o_imem_addr = pc_q;
        if (pres && !i_rst) begin
            o_instr_f          = W'(p_instr);
            o_pc_f             = p_pc;
            o_pc_p4_f          = p_pc + W'(4);
            o_exception_code_f = p_code;
            o_fetch_busy       = 1'b0;
        end else begin
            o_instr_f          = W'(NOP);
            o_pc_f             = '0;
            o_pc_p4_f          = '0;
            o_exception_code_f = NO_E;
            o_fetch_busy       = 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level program-order
// model plus a latency-randomized instruction memory.
module tb_fetch_unit;

    logic        i_clk;
    logic        i_rst;
    logic        i_clk_en;
    logic        i_stall_f;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;
    logic        i_trap_redirect;
    logic [63:0] i_trap_pc;
    logic        o_imem_req;
    logic [63:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic [63:0] o_instr_f;
    logic [63:0] o_pc_f;
    logic [63:0] o_pc_p4_f;
    logic [3:0]  o_exception_code_f;
    logic        o_fetch_busy;

    fetch_unit #(
        .XLEN(2),
        .RESET_VECTOR(64'h1000)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_clk_en(i_clk_en),
        .i_stall_f(i_stall_f),
        .i_redirect(i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .i_trap_redirect(i_trap_redirect),
        .i_trap_pc(i_trap_pc),
        .o_imem_req(o_imem_req),
        .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready),
        .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata),
        .i_imem_err(i_imem_err),
        .o_instr_f(o_instr_f),
        .o_pc_f(o_pc_f),
        .o_pc_p4_f(o_pc_p4_f),
        .o_exception_code_f(o_exception_code_f),
        .o_fetch_busy(o_fetch_busy)
    );

    localparam logic [3:0] NO_E = 4'hF;
    localparam logic [3:0] E_MIS = 4'd0;
    localparam logic [3:0] E_AF = 4'd1;
    localparam logic [63:0] NOP = 64'h13;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == 64'h1000) return 32'h0050_0093;
        return a[31:0] * 32'h9E37_79B1 ^ 32'h13;
    endfunction

    function automatic bit is_flt(input logic [63:0] a);
        return a[15:12] == 4'h3;
    endfunction

    function automatic logic [63:0] rand_tgt();
        logic [31:0] t;
        t = $urandom_range(0, 32'hFFFF) & ~32'h3;
        if ($urandom % 8 == 0) t = t | 32'h2;
        return 64'(t);
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [63:0] exp_pc;
    logic [63:0] pend_addr;
    logic [63:0] e_instr;
    logic [3:0]  e_code;
    bit          pend;
    bit          faulted;
    bit          ce, rd, tr, mis, flt;
    int          cnt;
    int          acc;

    initial begin
        i_rst = 1'b1;
        i_clk_en = 1'b1;
        i_stall_f = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_trap_redirect = 1'b0;
        i_trap_pc = '0;
        i_imem_ready = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata = '0;
        i_imem_err = 1'b0;
        exp_pc = 64'h1000;
        pend = 0;
        faulted = 0;
        cnt = 0;
        acc = 0;
        pend_addr = '0;

        @(negedge i_clk);
        i_clk_en = 1'b0;
        i_imem_ready = 1'b1;
        @(negedge i_clk);
        #1;
        chk("rst_req", 64'(o_imem_req), 64'd0);
        chk("rst_busy", 64'(o_fetch_busy), 64'd1);
        chk("rst_instr", o_instr_f, NOP);
        chk("rst_pc", o_pc_f, 64'd0);
        chk("rst_pcp4", o_pc_p4_f, 64'd0);
        chk("rst_code", 64'(o_exception_code_f), 64'(NO_E));
        i_rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge i_clk);
            if (cyc < 6) begin
                i_clk_en = 1'b1;
                i_stall_f = 1'b0;
                i_imem_ready = 1'b1;
                i_redirect = 1'b0;
                i_trap_redirect = 1'b0;
            end else begin
                i_clk_en = ($urandom % 8) != 0;
                i_stall_f = ($urandom % 4) == 0;
                i_imem_ready = $urandom % 2;
                i_redirect = ($urandom % 20) == 0;
                i_trap_redirect = ($urandom % 40) == 0;
            end
            i_redirect_pc = rand_tgt();
            i_trap_pc = rand_tgt();
            i_imem_rvalid = pend && cnt == 0;
            i_imem_rdata = i_imem_rvalid ? mem(pend_addr) : 32'h0;
            i_imem_err = i_imem_rvalid && is_flt(pend_addr);
            #1;
            ce = i_clk_en;
            rd = i_redirect;
            tr = i_trap_redirect;

            if (cyc == 0) chk("first_req", 64'(o_imem_req), 64'd1);
            if (cyc == 1) begin
                chk("first_busy", 64'(o_fetch_busy), 64'd0);
                chk("first_instr", o_instr_f, 64'h0050_0093);
            end
            if (cyc == 2) chk("next_addr", o_imem_addr, 64'h1004);

            if (o_fetch_busy) begin
                chk("bub_instr", o_instr_f, NOP);
                chk("bub_pc", o_pc_f, 64'd0);
                chk("bub_pcp4", o_pc_p4_f, 64'd0);
                chk("bub_code", 64'(o_exception_code_f), 64'(NO_E));
            end else begin
                chk("pcp4", o_pc_p4_f, o_pc_f + 64'd4);
            end

            if (faulted) begin
                chk("flt_busy", 64'(o_fetch_busy), 64'd1);
                chk("flt_noreq", 64'(o_imem_req), 64'd0);
            end else if (exp_pc[1:0] != 2'b00) begin
                chk("mis_noreq", 64'(o_imem_req), 64'd0);
            end

            if (o_imem_req) begin
                if (!faulted) chk("req_addr", o_imem_addr, exp_pc);
                if (i_imem_ready && ce)
                    chk("one_outst", 64'(pend), 64'd0);
            end

            if (ce && !rd && !tr && !o_fetch_busy && !i_stall_f) begin
                mis = exp_pc[1:0] != 2'b00;
                flt = is_flt(exp_pc);
                e_instr = (mis || flt) ? 64'd0 : 64'(mem(exp_pc));
                e_code = mis ? E_MIS : (flt ? E_AF : NO_E);
                chk("acc_pc", o_pc_f, exp_pc);
                chk("acc_instr", o_instr_f, e_instr);
                chk("acc_code", 64'(o_exception_code_f), 64'(e_code));
                acc++;
                if (mis || flt) faulted = 1;
                else exp_pc = exp_pc + 64'd4;
            end

            if (ce && (rd || tr)) begin
                exp_pc = tr ? i_trap_pc : i_redirect_pc;
                faulted = 0;
            end

            if (pend && cnt > 0) cnt--;
            if (ce && i_imem_rvalid) pend = 0;
            if (ce && o_imem_req && i_imem_ready) begin
                pend = 1;
                pend_addr = o_imem_addr;
                cnt = (cyc < 6) ? 0 : int'($urandom % 3);
            end
        end

        chk("liveness", 64'(acc >= 50), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
